// File: rtl/serial_tcmp_multi_pkg.sv
// Shared numerics for the serial two's complementer: default geometry and FSM encoding.
package serial_tcmp_multi_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CH    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_tcmp_lane.sv
// One bit-serial two's complement lane: "seen a 1" flag, registered output, optional overflow flag.
// Overflow logic is built only when OVF_DETECT_EN is defined.
module serial_tcmp_lane (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic neg_eff,
    input  logic active,
    input  logic last_bit,
    input  logic a
`ifdef OVF_DETECT_EN
    ,
    output logic ovf
`endif
    ,
    output logic s
);

    logic z;
    logic z_eff;

    // A start cycle is bit 0 of a fresh word, so the history is ignored.
    assign z_eff = start ? 1'b0 : z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= 1'b0;
            z <= 1'b0;
        end else begin
            s <= active & (a ^ (z_eff & neg_eff));
            z <= active & (z_eff | a);
        end
    end

`ifdef OVF_DETECT_EN
    // MSB is 1 with no earlier 1: negating -2^(WIDTH-1), which wraps to itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= last_bit & neg_eff & a & ~z;
        end
    end
`endif

endmodule

// File: rtl/serial_tcmp_multi.sv
// Multi-lane word-framed serial two's complementer: shared framing FSM plus CH serial lanes.
// Define OVF_DETECT_EN to add the per-lane ovf output.
module serial_tcmp_multi
    import serial_tcmp_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CH    = DEF_CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CH-1:0] neg_en,
    input  logic [CH-1:0] a,
    output logic [CH-1:0] s,
    output logic          valid,
    output logic          last,
`ifdef OVF_DETECT_EN
    output logic [CH-1:0] ovf,
`endif
    output logic          busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CH-1:0] neg_q;
    logic          in_run;
    logic          msb_bit;
    logic          active;

    assign in_run  = (state == RUN);
    assign msb_bit = in_run && (cnt == LAST_CNT) && !start;
    assign active  = start | in_run;
    assign busy    = in_run;

    // start wins over everything, including the MSB cycle of the current word.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (start) begin
            state_nx = RUN;
            cnt_nx   = CW'(1);
        end else if (in_run) begin
            if (cnt == LAST_CNT) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end else begin
            cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            neg_q <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                neg_q <= neg_en;
            end
            valid <= active;
            last  <= msb_bit;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        serial_tcmp_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .neg_eff  (start ? neg_en[i] : neg_q[i]),
            .active   (active),
            .last_bit (msb_bit),
            .a        (a[i]),
`ifdef OVF_DETECT_EN
            .ovf      (ovf[i]),
`endif
            .s        (s[i])
        );
    end

endmodule

// File: tb/tb_serial_tcmp_multi.sv
// Directed bench for serial_tcmp_multi (WIDTH=8, CH=2); ovf checks are active when OVF_DETECT_EN is defined.
module tb_serial_tcmp_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] neg_en;
    logic [1:0] a;
    logic [1:0] s;
    logic       valid;
    logic       last;
    logic       busy;
`ifdef OVF_DETECT_EN
    logic [1:0] ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] r0, r1, lm;
    logic [1:0] ov;
    int         vc;

    serial_tcmp_multi #(.WIDTH(8), .CH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .neg_en (neg_en),
        .a      (a),
        .s      (s),
        .valid  (valid),
        .last   (last),
`ifdef OVF_DETECT_EN
        .ovf    (ovf),
`endif
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs for one cycle; outputs are read 1 time unit after the edge that consumed them.
    task automatic step(input logic st, input logic [1:0] ne, input logic [1:0] av);
        start  = st;
        neg_en = ne;
        a      = av;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] neg,
                              input int nbits, input bit toggle,
                              output logic [7:0] o0, output logic [7:0] o1, output logic [7:0] lmask,
                              output int vcnt, output logic [1:0] ovl);
        o0 = '0; o1 = '0; lmask = '0; vcnt = 0; ovl = '0;
        for (int i = 0; i < nbits; i++) begin
            step(i == 0, (i != 0 && toggle) ? ~neg : neg, {w1[i], w0[i]});
            o0[i]    = s[0];
            o1[i]    = s[1];
            lmask[i] = last;
            if (valid) vcnt++;
`ifdef OVF_DETECT_EN
            if (last) ovl = ovf;
`endif
        end
    endtask

    task automatic idle_check(input string tag);
        step(1'b0, 2'b11, 2'b11);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_s"}, s, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; neg_en = '0; a = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", s, 2'b00);
        check("rst_valid", valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef OVF_DETECT_EN
        check("rst_ovf", ovf, 2'b00);
`endif
        rst = 1'b0;
        idle_check("idle0");

        // Negate lane 0, pass lane 1.
        drive_word(8'h05, 8'h5A, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("np_s0", r0, 8'hFB);
        check("np_s1", r1, 8'h5A);
        check("np_vcnt", vc, 8);
        check("np_last", lm, 8'h80);
        check("np_busy_end", busy, 1'b0);
        idle_check("np_idle");

        // Zero and most negative value.
        drive_word(8'h00, 8'h80, 2'b11, 8, 1'b0, r0, r1, lm, vc, ov);
        check("zm_s0", r0, 8'h00);
        check("zm_s1", r1, 8'h80);
        check("zm_last", lm, 8'h80);
`ifdef OVF_DETECT_EN
        check("zm_ovf", ov, 2'b10);
`endif
        drive_word(8'h7F, 8'h7F, 2'b11, 8, 1'b0, r0, r1, lm, vc, ov);
        check("max_s0", r0, 8'h81);
        check("max_s1", r1, 8'h81);
`ifdef OVF_DETECT_EN
        check("max_ovf", ov, 2'b00);
`endif
        idle_check("zm_idle");

        // Back-to-back words, lane 0 negates and lane 1 passes.
        drive_word(8'h01, 8'h01, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("b2b0_s0", r0, 8'hFF);
        check("b2b0_s1", r1, 8'h01);
        check("b2b0_vcnt", vc, 8);
        check("b2b0_last", lm, 8'h80);
        drive_word(8'hFF, 8'hFF, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("b2b1_s0", r0, 8'h01);
        check("b2b1_s1", r1, 8'hFF);
        check("b2b1_vcnt", vc, 8);
        check("b2b1_last", lm, 8'h80);
        drive_word(8'h10, 8'h10, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("b2b2_s0", r0, 8'hF0);
        check("b2b2_s1", r1, 8'h10);
        check("b2b2_vcnt", vc, 8);
        check("b2b2_last", lm, 8'h80);
        idle_check("b2b_idle");

        // Mid-word restart after 4 bits of 0x0F.
        drive_word(8'h0F, 8'h0F, 2'b01, 4, 1'b0, r0, r1, lm, vc, ov);
        check("trunc_s0", r0, 8'h01);
        check("trunc_s1", r1, 8'h0F);
        check("trunc_last", lm, 8'h00);
        check("trunc_vcnt", vc, 4);
        check("trunc_busy", busy, 1'b1);
        drive_word(8'h03, 8'h03, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("restart_s0", r0, 8'hFD);
        check("restart_s1", r1, 8'h03);
        check("restart_last", lm, 8'h80);
        idle_check("restart_idle");

        // neg_en changes during bits 1..7 must not affect the word in flight.
        drive_word(8'h3C, 8'h3C, 2'b10, 8, 1'b1, r0, r1, lm, vc, ov);
        check("tog_s0", r0, 8'h3C);
        check("tog_s1", r1, 8'hC4);
        drive_word(8'h01, 8'h01, 2'b01, 8, 1'b0, r0, r1, lm, vc, ov);
        check("tog_next_s0", r0, 8'hFF);
        check("tog_next_s1", r1, 8'h01);

        // Asynchronous reset at bit 3.
        drive_word(8'hFF, 8'hFF, 2'b11, 3, 1'b0, r0, r1, lm, vc, ov);
        check("prerst_busy", busy, 1'b1);
        check("prerst_valid", valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_s", s, 2'b00);
        check("arst_valid", valid, 1'b0);
        check("arst_last", last, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("arst_idle");
        drive_word(8'h02, 8'h02, 2'b11, 8, 1'b0, r0, r1, lm, vc, ov);
        check("postrst_s0", r0, 8'hFE);
        check("postrst_s1", r1, 8'hFE);
        check("postrst_last", lm, 8'h80);
        check("postrst_vcnt", vc, 8);
        idle_check("end_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
